// File: rtl/dvp_capture.sv
// -----------------------------------------------------------------------------
// dvp_capture
//   Captures pixels from a DVP camera sensor (vsync/href/8-bit data) into whole
//   pixels, with frame/line markers, error pulses and a completed-frame counter.
//   A frame is armed at the end of a vsync pulse while enable=1. Lines are
//   delimited by href. Malformed lines and aborted frames are flagged.
//
// Ports
//   pclk      in   pixel clock, all logic on rising edge
//   rst_n     in   asynchronous active-low reset
//   enable    in   arms capture of the next frame (sampled at vsync pulse end)
//   vsync     in   frame sync, active level set by VSYNC_POL
//   href      in   line valid
//   data      in   8-bit sensor byte
//   outData   out  assembled pixel, first received byte in the MSBs
//   outValid  out  one-cycle pixel strobe
//   outSof    out  first pixel of frame (qualified by outValid)
//   outEol    out  last pixel of line   (qualified by outValid)
//   outEof    out  last pixel of frame  (qualified by outValid)
//   lineErr   out  one-cycle pulse on a malformed line
//   frameErr  out  one-cycle pulse on an aborted frame
//   frameCnt  out  completed frames, wraps 0xFFFF -> 0
// -----------------------------------------------------------------------------
module dvp_capture #(
   parameter int WIDTH           = 1280,
   parameter int HEIGHT          = 720,
   parameter int BYTES_PER_PIXEL = 2,
   parameter int VSYNC_POL       = 1
) (
   input  logic                         pclk,
   input  logic                         rst_n,
   input  logic                         enable,
   input  logic                         vsync,
   input  logic                         href,
   input  logic [7:0]                   data,
   output logic [8*BYTES_PER_PIXEL-1:0] outData,
   output logic                         outValid,
   output logic                         outSof,
   output logic                         outEol,
   output logic                         outEof,
   output logic                         lineErr,
   output logic                         frameErr,
   output logic [15:0]                  frameCnt
);

   localparam int OW = 8 * BYTES_PER_PIXEL;
   localparam int BW = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
   localparam int PW = $clog2(WIDTH + 1);
   localparam int LW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   localparam logic [BW-1:0] LAST_BYTE = BW'(BYTES_PER_PIXEL - 1);
   localparam logic [PW-1:0] PIX_FULL  = PW'(WIDTH);
   localparam logic [PW-1:0] PIX_LAST  = PW'(WIDTH - 1);
   localparam logic [LW-1:0] LAST_LINE = LW'(HEIGHT - 1);
   localparam logic          VS_ACT    = (VSYNC_POL != 0);

   typedef enum logic [1:0] {IDLE, ARMED, BLANK, LINE} state_t;

   state_t          state, state_d;
   logic            vs_act_q;
   logic [BW-1:0]   byte_cnt;
   logic [PW-1:0]   pix_cnt;
   logic [LW-1:0]   line_cnt;
   logic            over_q;     // a complete pixel past WIDTH was dropped
   logic [OW-1:0]   pix_sr;     // byte shift register, oldest byte in MSBs

   logic            vs_act, vs_start, vs_end;
   logic            frame_full, abort, take_byte, last_byte, emit;
   logic            line_end, line_bad, is_eol, is_eof;
   logic [OW-1:0]   next_pix;

   assign vs_act   = (vsync == VS_ACT);
   assign vs_start = vs_act & ~vs_act_q;
   assign vs_end   = ~vs_act & vs_act_q;

   // Once the EOF pixel has gone out the frame is complete; a vsync rise
   // while href is still high must not turn it into an abort.
   assign frame_full = (line_cnt == LAST_LINE) && (pix_cnt == PIX_FULL);
   assign abort      = (state != IDLE) && vs_start && !((state == LINE) && frame_full);

   // Abort has priority over a byte arriving in the same cycle.
   assign take_byte = !abort && href && (state != IDLE);
   assign last_byte = take_byte && (byte_cnt == LAST_BYTE);
   assign emit      = last_byte && (pix_cnt != PIX_FULL);
   // LINE is only entered with href=1, so href=0 in LINE is the falling edge.
   assign line_end  = !abort && (state == LINE) && !href;
   assign line_bad  = line_end && ((byte_cnt != '0) || (pix_cnt != PIX_FULL) || over_q);
   assign is_eol    = (pix_cnt == PIX_LAST);
   assign is_eof    = is_eol && (line_cnt == LAST_LINE);
   assign next_pix  = (pix_sr << 8) | OW'(data);

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state;
      case (state)
         IDLE:         if (vs_end && enable) state_d = ARMED;
         ARMED, BLANK: begin
            if (abort)     state_d = IDLE;
            else if (href) state_d = LINE;
         end
         LINE: begin
            if (abort)         state_d = IDLE;
            else if (line_end) state_d = (line_cnt == LAST_LINE) ? IDLE : BLANK;
         end
         default:      state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         vs_act_q <= 1'b0;
         byte_cnt <= '0;
         pix_cnt  <= '0;
         line_cnt <= '0;
         over_q   <= 1'b0;
         pix_sr   <= '0;
         outData  <= '0;
         outValid <= 1'b0;
         outSof   <= 1'b0;
         outEol   <= 1'b0;
         outEof   <= 1'b0;
         lineErr  <= 1'b0;
         frameErr <= 1'b0;
         frameCnt <= '0;
      end else begin
         vs_act_q <= vs_act;
         outValid <= 1'b0;
         outSof   <= 1'b0;
         outEol   <= 1'b0;
         outEof   <= 1'b0;
         lineErr  <= line_bad;
         frameErr <= abort;

         if ((state == IDLE) || abort) begin
            // Any partial pixel or line bookkeeping is discarded.
            byte_cnt <= '0;
            pix_cnt  <= '0;
            line_cnt <= '0;
            over_q   <= 1'b0;
         end else begin
            if (take_byte) begin
               pix_sr   <= next_pix;
               byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
               if (emit) begin
                  outData  <= next_pix;
                  outValid <= 1'b1;
                  outSof   <= (pix_cnt == '0) && (line_cnt == '0);
                  outEol   <= is_eol;
                  outEof   <= is_eof;
                  pix_cnt  <= pix_cnt + 1'b1;
                  if (is_eof) frameCnt <= frameCnt + 16'd1;
               end else if (last_byte) begin
                  over_q <= 1'b1;
               end
            end
            if (line_end) begin
               byte_cnt <= '0;
               pix_cnt  <= '0;
               over_q   <= 1'b0;
               line_cnt <= (line_cnt == LAST_LINE) ? '0 : line_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_dvp_capture.sv
// -----------------------------------------------------------------------------
// tb_dvp_capture
//   Directed self-checking bench for dvp_capture with WIDTH=4, HEIGHT=2,
//   BYTES_PER_PIXEL=2, VSYNC_POL=1. Every line carries bytes 0x01,0x02,...
//   so pixel p of a captured line is {2p+1, 2p+2}.
// -----------------------------------------------------------------------------
module tb_dvp_capture;

   logic        pclk;
   logic        rst_n;
   logic        enable;
   logic        vsync;
   logic        href;
   logic [7:0]  data;
   logic [15:0] outData;
   logic        outValid, outSof, outEol, outEof;
   logic        lineErr, frameErr;
   logic [15:0] frameCnt;

   int n_checks = 0;
   int n_fail   = 0;

   dvp_capture #(
      .WIDTH(4), .HEIGHT(2), .BYTES_PER_PIXEL(2), .VSYNC_POL(1)
   ) dut (
      .pclk(pclk), .rst_n(rst_n), .enable(enable), .vsync(vsync),
      .href(href), .data(data), .outData(outData), .outValid(outValid),
      .outSof(outSof), .outEol(outEol), .outEof(outEof),
      .lineErr(lineErr), .frameErr(frameErr), .frameCnt(frameCnt)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, observed running expected done");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   // vsync pulse of two cycles, pulse end sampled with the given enable,
   // followed by one blanking cycle.
   task automatic frame_start(input logic en);
      enable = en;
      vsync  = 1'b1; href = 1'b0;
      tick(); tick();
      vsync  = 1'b0;
      tick();
      chk("frame_err_start", frameErr, 0);
      tick();
   endtask

   // Drive n bytes with href=1 and check the pixel stream cycle by cycle.
   task automatic send_bytes(input int n, input int line_idx, input bit cap);
      bit exp_valid;
      int pix;
      for (int i = 0; i < n; i++) begin
         href = 1'b1;
         data = 8'(i + 1);
         tick();
         exp_valid = cap && (i % 2 == 1) && (i / 2 < 4);
         chk("valid", outValid, exp_valid);
         if (exp_valid) begin
            pix = i / 2;
            chk("data", outData, {8'(i), 8'(i + 1)});
            chk("sof", outSof, (pix == 0) && (line_idx == 0));
            chk("eol", outEol, pix == 3);
            chk("eof", outEof, (pix == 3) && (line_idx == 1));
         end
         chk("line_err_mid", lineErr, 0);
      end
   endtask

   // href fall: lineErr must pulse exactly once when expected.
   task automatic end_line(input bit exp_err);
      href = 1'b0;
      data = 8'h00;
      tick();
      chk("line_err_fall", lineErr, exp_err);
      chk("valid_fall", outValid, 0);
      tick();
      chk("line_err_single", lineErr, 0);
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; vsync = 1'b0; href = 1'b0; data = 8'h00;
      tick(); tick();
      chk("rst_valid", outValid, 0);
      chk("rst_data", outData, 0);
      chk("rst_cnt", frameCnt, 0);
      chk("rst_errs", {lineErr, frameErr, outSof, outEol, outEof}, 0);
      rst_n = 1'b1;
      tick();

      // Nominal frame: 2 lines x 8 bytes.
      frame_start(1'b1);
      send_bytes(8, 0, 1'b1); end_line(1'b0);
      send_bytes(8, 1, 1'b1); end_line(1'b0);
      chk("cnt_nominal", frameCnt, 1);
      chk("data_hold", outData, 16'h0708);

      // Short first line of 7 bytes: 3 pixels, lineErr, frame still ends with EOF.
      frame_start(1'b1);
      send_bytes(7, 0, 1'b1); end_line(1'b1);
      send_bytes(8, 1, 1'b1); end_line(1'b0);
      chk("cnt_short", frameCnt, 2);

      // Long first line of 10 bytes: 4 pixels, 5th dropped, one lineErr.
      frame_start(1'b1);
      send_bytes(10, 0, 1'b1); end_line(1'b1);
      send_bytes(8, 1, 1'b1); end_line(1'b0);
      chk("cnt_long", frameCnt, 3);

      // Abort during line 1, with vsync rising on a last-byte cycle.
      frame_start(1'b1);
      send_bytes(8, 0, 1'b1); end_line(1'b0);
      send_bytes(3, 1, 1'b1);
      vsync = 1'b1; href = 1'b1; data = 8'h04;
      tick();
      chk("abort_no_pixel", outValid, 0);
      chk("abort_frame_err", frameErr, 1);
      href = 1'b0;
      tick();
      chk("abort_err_single", frameErr, 0);
      chk("abort_no_eof", outEof, 0);
      chk("cnt_abort", frameCnt, 3);
      // vsync is still high here; frame_start ends this pulse and re-arms.
      frame_start(1'b1);
      send_bytes(8, 0, 1'b1); end_line(1'b0);
      send_bytes(8, 1, 1'b1); end_line(1'b0);
      chk("cnt_after_abort", frameCnt, 4);

      // enable low at vsync fall: whole frame ignored.
      frame_start(1'b0);
      send_bytes(8, 0, 1'b0); end_line(1'b0);
      send_bytes(8, 1, 1'b0); end_line(1'b0);
      chk("cnt_disabled", frameCnt, 4);

      // enable dropped mid-frame: frame still completes.
      frame_start(1'b1);
      send_bytes(8, 0, 1'b1);
      enable = 1'b0;
      end_line(1'b0);
      send_bytes(8, 1, 1'b1); end_line(1'b0);
      chk("cnt_enable_drop", frameCnt, 5);

      // Reset for one cycle mid-line: outputs cleared, no capture until a new pulse end.
      frame_start(1'b1);
      send_bytes(3, 0, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", outValid, 0);
      chk("midrst_data", outData, 0);
      chk("midrst_cnt", frameCnt, 0);
      chk("midrst_flags", {lineErr, frameErr, outSof, outEol, outEof}, 0);
      tick();
      rst_n = 1'b1;
      send_bytes(5, 0, 1'b0); end_line(1'b0);
      send_bytes(8, 1, 1'b0); end_line(1'b0);
      chk("midrst_cnt_hold", frameCnt, 0);
      frame_start(1'b1);
      send_bytes(8, 0, 1'b1); end_line(1'b0);
      send_bytes(8, 1, 1'b1); end_line(1'b0);
      chk("cnt_after_rst", frameCnt, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dvp_capture.md
DVP_CAPTURE -- requirements
Module: dvp_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 1280, meaning active pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 720, meaning active lines per frame.
REQ-003 SHALL have parameter BYTES_PER_PIXEL, default 2, legal 1..4, meaning bytes per pixel on the DVP bus.
REQ-004 SHALL have parameter VSYNC_POL, default 1, meaning the vsync active level.
REQ-005 SHALL have port pclk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port enable, input, 1, arms capture of the next frame.
REQ-008 SHALL have ports vsync, href, input, 1 each, sensor sync; data, input, 8, sensor byte.
REQ-009 SHALL have port outData, output, 8*BYTES_PER_PIXEL, assembled pixel with the first received byte in the MSBs.
REQ-010 SHALL have port outValid, output, 1, one-cycle pixel strobe.
REQ-011 SHALL have ports outSof, outEol, outEof, output, 1 each, qualified by outValid: first pixel of frame, last pixel of line, last pixel of frame.
REQ-012 SHALL have port lineErr, output, 1, one-cycle pulse on a malformed line.
REQ-013 SHALL have port frameErr, output, 1, one-cycle pulse on an aborted frame.
REQ-014 SHALL have port frameCnt, output, 16, count of completed frames, wrapping at 0xFFFF->0.

Function
REQ-015 SHALL implement states IDLE, ARMED, BLANK and LINE.
REQ-016 IDLE->ARMED SHALL occur on a vsync transition from active to inactive (end of pulse) while enable=1; otherwise the block SHALL stay in IDLE.
REQ-017 ARMED->LINE and BLANK->LINE SHALL occur on the first cycle with href=1, and that cycle's byte SHALL be captured.
REQ-018 LINE->BLANK SHALL occur when href=0 and fewer than HEIGHT lines are complete; LINE->IDLE SHALL occur when line HEIGHT-1 ends.
REQ-019 Bytes SHALL be assembled by a byte counter 0..BYTES_PER_PIXEL-1 that advances only while href=1 in LINE or on the ARMED/BLANK entry cycle.
REQ-020 On the last byte, outData SHALL load {previous bytes, data} and outValid SHALL assert the following cycle (latency 1 pclk from the last byte).
REQ-021 The pixel counter SHALL range 0..WIDTH-1; outEol SHALL assert with pixel WIDTH-1.
REQ-022 outSof SHALL assert with pixel 0 of line 0; outEof SHALL assert with pixel WIDTH-1 of line HEIGHT-1, together with outEol.
REQ-023 Pixels beyond WIDTH in a line SHALL be dropped with outValid=0; lineErr SHALL pulse once at that line's href fall.
REQ-024 An href fall with a partial pixel or fewer than WIDTH pixels SHALL pulse lineErr; the partial pixel SHALL be discarded; the line SHALL count toward HEIGHT.
REQ-025 The byte and pixel counters SHALL clear on every href fall.
REQ-026 vsync going active in ARMED, BLANK or LINE before outEof SHALL pulse frameErr, discard the partial pixel, and return to IDLE; frameCnt SHALL be unchanged.
REQ-027 frameCnt SHALL increment in the cycle outEof is presented.
REQ-028 Deasserting enable mid-frame SHALL NOT abort the frame; enable SHALL be sampled only at the IDLE->ARMED decision.
REQ-029 A simultaneous vsync active transition and a last-byte cycle SHALL take the abort path; no pixel SHALL be emitted.
REQ-030 outData SHALL hold its value when outValid=0.

Reset
REQ-031 While rst_n=0, the state SHALL be IDLE; all counters, outData, outValid, outSof, outEol, outEof, lineErr, frameErr and frameCnt SHALL be 0.
REQ-032 Reset asserted mid-line SHALL discard all partial data; after release, capture SHALL need a fresh vsync pulse end.

Verification (WIDTH=4, HEIGHT=2, BYTES_PER_PIXEL=2, VSYNC_POL=1)
REQ-033 Nominal frame, enable=1, 2 lines of 8 bytes 0x01..0x08 -> outData 0x0102, 0x0304, 0x0506, 0x0708 per line, each 1 cycle after its 2nd byte; SOF on first, EOL on 4th and 8th, EOF on 8th; frameCnt=1.
REQ-034 Line of 7 bytes -> 3 pixels, lineErr pulse at href fall; next line captured normally; EOF still on line 1 pixel 3.
REQ-035 Line of 10 bytes -> 4 pixels emitted, 5th dropped, single lineErr pulse.
REQ-036 vsync=1 during line 1 -> frameErr pulse, no EOF, frameCnt unchanged, next full frame captured correctly.
REQ-037 enable=0 at vsync fall -> no outValid for that frame; enable=0 mid-frame -> frame completes.
REQ-038 rst_n low for 1 cycle mid-line -> all outputs 0; no output until the next vsync fall.
